lcd_spi_write: RTL



---
 rtl/lcd_pkg.sv | 28 ++
 rtl/lcd_spi_write.sv | 139 +++++++++++++
 2 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD SPI write path and its upstream sequencers.
package lcd_pkg;

    // One-hot bit positions of the serializer states
    localparam int IDLE_B  = 0;
    localparam int SHIFT_B = 1;
    localparam int HOLD_B  = 2;
    localparam int DONE_B  = 3;
    localparam int GAP_B   = 4;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'(1 << IDLE_B),
        ST_SHIFT = 5'(1 << SHIFT_B),
        ST_HOLD  = 5'(1 << HOLD_B),
        ST_DONE  = 5'(1 << DONE_B),
        ST_GAP   = 5'(1 << GAP_B)
    } state_t;

    // D/C pin levels carried in bit 8 of a word
    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    // Panel opcodes used by the drawing sequencers
    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

endpackage

// File: rtl/lcd_spi_write.sv
// Mode-0 SPI serializer for 9-bit {dc, byte} LCD words, MSB first,
// with a CS hold phase and a fixed idle gap between words.
module lcd_spi_write
    import lcd_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       en_write,
    input  logic [8:0] wr_data,
    output logic       wr_done,
    output logic       busy,
    output logic       lcd_cs,
    output logic       lcd_sclk,
    output logic       lcd_mosi,
    output logic       lcd_dc
);

    localparam int HW = $clog2(CLK_DIV) + 1;
    localparam logic [HW-1:0] HCNT_MAX = HW'(CLK_DIV - 1);
    // GAP state is left one cycle early: the following IDLE cycle is the
    // last gap cycle, so en_write is next sampled GAP_CYCLES+1 edges after wr_done.
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 2);

    state_t          state, state_d;
    logic [HW-1:0]   hcnt, hcnt_d;
    logic [2:0]      bcnt, bcnt_d;
    logic [3:0]      gcnt, gcnt_d;
    logic [7:0]      shift_reg, shift_d;
    logic            cs_d, sclk_d, mosi_d, dc_d, done_d, busy_d;

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_d = state;
        hcnt_d  = hcnt;
        bcnt_d  = bcnt;
        gcnt_d  = gcnt;
        shift_d = shift_reg;
        cs_d    = lcd_cs;
        sclk_d  = lcd_sclk;
        mosi_d  = lcd_mosi;
        dc_d    = lcd_dc;
        done_d  = 1'b0;
        busy_d  = busy;
        unique case (state)
            ST_IDLE: begin
                if (en_write) begin
                    shift_d = wr_data[7:0];
                    dc_d    = wr_data[8];
                    mosi_d  = wr_data[7];
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    hcnt_d  = '0;
                    bcnt_d  = 3'd7;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (hcnt == HCNT_MAX) begin
                    hcnt_d = '0;
                    if (!lcd_sclk) begin
                        sclk_d = 1'b1;
                    end else if (bcnt == 3'd0) begin
                        sclk_d  = 1'b0;
                        state_d = ST_HOLD;
                    end else begin
                        // next bit goes out on the falling edge of SCLK
                        sclk_d = 1'b0;
                        bcnt_d = bcnt - 3'd1;
                        mosi_d = shift_reg[bcnt - 3'd1];
                    end
                end else begin
                    hcnt_d = hcnt + 1'b1;
                end
            end
            ST_HOLD: begin
                if (hcnt == HCNT_MAX) begin
                    hcnt_d  = '0;
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    hcnt_d = hcnt + 1'b1;
                end
            end
            ST_DONE: begin
                gcnt_d  = 4'd0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gcnt == GAP_LAST) begin
                    gcnt_d  = 4'd0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    gcnt_d = gcnt + 4'd1;
                end
            end
            default: begin
                cs_d    = 1'b1;
                sclk_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and output registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            hcnt      <= '0;
            bcnt      <= 3'd0;
            gcnt      <= 4'd0;
            shift_reg <= 8'd0;
            lcd_cs    <= 1'b1;
            lcd_sclk  <= 1'b0;
            lcd_mosi  <= 1'b0;
            lcd_dc    <= 1'b0;
            wr_done   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            hcnt      <= hcnt_d;
            bcnt      <= bcnt_d;
            gcnt      <= gcnt_d;
            shift_reg <= shift_d;
            lcd_cs    <= cs_d;
            lcd_sclk  <= sclk_d;
            lcd_mosi  <= mosi_d;
            lcd_dc    <= dc_d;
            wr_done   <= done_d;
            busy      <= busy_d;
        end
    end

endmodule
